// File: rtl/elk_shift_seq.sv
// elk_shift_seq: multi-cycle shift/rotate slot peripheral, STEP bits per cycle.
// Optional done interrupt output enabled by defining ELK_SHIFT_IRQ_EN.
module elk_shift_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
`ifdef ELK_SHIFT_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] rd_data
);

    localparam int AW = $clog2(WIDTH);

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_CTRL   = 5'd1;
    localparam logic [4:0] A_RESULT = 5'd2;
    localparam logic [4:0] A_STATUS = 5'd3;

    localparam logic [AW:0] STEP_K  = (AW+1)'(STEP);
    localparam logic [AW:0] WIDTH_K = (AW+1)'(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        M_LSR = 2'b00,
        M_LSL = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] result_q;
    logic [AW-1:0]    remain_q;
    mode_t            mode_q;
    logic             done_q;
    logic             ovr_q;

    logic             busy;
    logic             wr_en;
    logic             rd_en;
    logic             sel_data;
    logic             sel_ctrl;
    logic             sel_result;
    logic             sel_status;
    logic             wr_data_reg;
    logic             wr_ctrl;
    logic             wr_status;
    logic             start_go;
    logic             ovr_set;

    logic [AW:0]      k;
    logic [AW:0]      rk;
    logic [WIDTH-1:0] shifted;
    logic [AW-1:0]    remain_nx;
    logic             last;
    logic [31:0]      rd_val;
    logic             unused_wr_bits;

    // every wr_data bit is referenced here so narrow builds stay lint-quiet
    assign unused_wr_bits = ^wr_data;

    assign busy       = (state == SHIFT);
    assign wr_en      = cs && write;
    assign rd_en      = cs && read;
    assign sel_data   = (addr == A_DATA);
    assign sel_ctrl   = (addr == A_CTRL);
    assign sel_result = (addr == A_RESULT);
    assign sel_status = (addr == A_STATUS);

    assign wr_data_reg = wr_en && sel_data;
    assign wr_ctrl     = wr_en && sel_ctrl;
    assign wr_status   = wr_en && sel_status;
    assign start_go    = wr_ctrl && !busy && wr_data[8];
    assign ovr_set     = (wr_data_reg || wr_ctrl) && busy;

    always_comb begin
        k = {1'b0, remain_q};
        if ({1'b0, remain_q} >= STEP_K) begin
            k = STEP_K;
        end
        rk = WIDTH_K - k;
    end

    always_comb begin
        shifted = work_q;
        unique case (mode_q)
            M_LSR: shifted = work_q >> k;
            M_LSL: shifted = work_q << k;
            M_ASR: shifted = $signed(work_q) >>> k;
            M_ROR: shifted = (work_q >> k) | (work_q << rk);
            default: shifted = work_q;
        endcase
    end

    // k never exceeds remain_q, so the low AW bits carry the whole step
    assign remain_nx = remain_q - k[AW-1:0];
    assign last      = (remain_nx == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_go) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            work_q   <= '0;
            result_q <= '0;
            remain_q <= '0;
            mode_q   <= M_LSR;
            done_q   <= 1'b0;
        end else begin
            if (wr_data_reg && !busy) begin
                data_q <= wr_data[WIDTH-1:0];
            end
            if (start_go) begin
                work_q   <= data_q;
                remain_q <= wr_data[AW-1:0];
                mode_q   <= mode_t'(wr_data[6:5]);
                done_q   <= 1'b0;
            end else if (busy) begin
                work_q   <= shifted;
                remain_q <= remain_nx;
                if (last) begin
                    result_q <= shifted;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (wr_status && wr_data[2]) begin
            ovr_q <= 1'b0;
        end
    end

`ifdef ELK_SHIFT_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q <= 1'b0;
        end else if (wr_ctrl && !busy) begin
            ie_q <= wr_data[9];
        end
    end

    assign irq = done_q && ie_q;
`endif

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_data:   rd_val = 32'(data_q);
            sel_result: rd_val = 32'(result_q);
            sel_status: rd_val = {29'd0, ovr_q, done_q, busy};
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_elk_shift_seq.sv
// Directed bench for elk_shift_seq: a 32-bit/STEP 4 and an 8-bit/STEP 1 instance.
// Both sit on one shared bus; sel chooses which instance sees cs.
module tb_elk_shift_seq;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic        sel;
    logic        cs0;
    logic        cs1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rdd;
`ifdef ELK_SHIFT_IRQ_EN
    logic        irq0;
    logic        irq1;
`endif

    int compared;
    int mismatched;

    assign cs0 = cs && !sel;
    assign cs1 = cs && sel;
    assign rdd = sel ? rd1 : rd0;

    elk_shift_seq #(.WIDTH(32), .STEP(4)) u0 (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs0),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
`ifdef ELK_SHIFT_IRQ_EN
        .irq     (irq0),
`endif
        .rd_data (rd0)
    );

    elk_shift_seq #(.WIDTH(8), .STEP(1)) u1 (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs1),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
`ifdef ELK_SHIFT_IRQ_EN
        .irq     (irq1),
`endif
        .rd_data (rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1;
        write = 1'b1;
        read = 1'b0;
        addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1;
        read = 1'b1;
        write = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0;
        read = 1'b0;
        d = rdd;
    endtask

    // each read sampled at edge t+j reports the status left by edge t+j-1
    task automatic poll(output int n, output logic [31:0] st);
        n = 0;
        @(negedge clk);
        cs = 1'b1;
        read = 1'b1;
        write = 1'b0;
        addr = 5'd3;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (!rdd[0]) break;
            n++;
        end
        cs = 1'b0;
        read = 1'b0;
        st = rdd;
    endtask

    task automatic run_op(input string tag, input logic [31:0] d,
                          input logic [31:0] c, input logic [31:0] exp_res,
                          input int exp_n);
        int n;
        logic [31:0] st;
        logic [31:0] r;
        bus_wr(5'd0, d);
        bus_wr(5'd1, c);
        poll(n, st);
        check({tag, " busy"}, 32'(n), 32'(exp_n));
        check({tag, " status"}, st, 32'h2);
        bus_rd(5'd2, r);
        check({tag, " result"}, r, exp_res);
    endtask

    initial begin
        logic [31:0] r;
        int n;
        compared = 0;
        mismatched = 0;
        cs = 1'b0;
        read = 1'b0;
        write = 1'b0;
        addr = '0;
        wr_data = '0;
        sel = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_data", rdd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        bus_rd(5'd0, r);
        check("reset data", r, 32'h0);
        bus_rd(5'd2, r);
        check("reset result", r, 32'h0);
        bus_rd(5'd3, r);
        check("reset status", r, 32'h0);

        run_op("lsr4", 32'h8000_0001, 32'h104, 32'h0800_0000, 1);
        run_op("asr31", 32'h8000_0000, 32'h15F, 32'hFFFF_FFFF, 8);
        run_op("ror8", 32'h1234_5678, 32'h168, 32'h7812_3456, 2);
        run_op("lsl0", 32'hA5A5_A5A5, 32'h120, 32'hA5A5_A5A5, 1);

        bus_wr(5'd0, 32'h8000_0000);
        bus_wr(5'd1, 32'h15F);
        bus_wr(5'd1, 32'h104);
        bus_wr(5'd0, 32'h0000_0001);
        bus_rd(5'd2, r);
        check("ovr old result", r, 32'hA5A5_A5A5);
        poll(n, r);
        check("ovr status", r, 32'h6);
        bus_rd(5'd2, r);
        check("ovr result", r, 32'hFFFF_FFFF);
        bus_rd(5'd0, r);
        check("ovr data kept", r, 32'h8000_0000);
        bus_wr(5'd3, 32'h4);
        bus_rd(5'd3, r);
        check("ovr cleared", r, 32'h2);

        bus_wr(5'd4, 32'hDEAD_BEEF);
        bus_rd(5'd0, r);
        check("unmapped wr", r, 32'h8000_0000);
        bus_rd(5'd4, r);
        check("unmapped rd", r, 32'h0);

        bus_rd(5'd2, r);
        bus_wr(5'd0, 32'h8000_0000);
        bus_wr(5'd1, 32'h15F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort rd_data", rdd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(5'd3, r);
        check("abort status", r, 32'h0);
        bus_rd(5'd2, r);
        check("abort result", r, 32'h0);
        bus_rd(5'd0, r);
        check("abort data", r, 32'h0);
        run_op("post ror8", 32'h1234_5678, 32'h168, 32'h7812_3456, 2);

        sel = 1'b1;
        bus_wr(5'd0, 32'h0000_01FF);
        bus_rd(5'd0, r);
        check("w8 data trunc", r, 32'h0000_00FF);
        run_op("w8 lsl3", 32'h0000_01FF, 32'h323, 32'h0000_00F8, 3);
`ifdef ELK_SHIFT_IRQ_EN
        check("w8 irq set", 32'(irq1), 32'h1);
        check("w32 irq idle", 32'(irq0), 32'h0);
`endif
        run_op("w8 ror1", 32'h0000_0081, 32'h161, 32'h0000_00C0, 1);
`ifdef ELK_SHIFT_IRQ_EN
        check("w8 irq off", 32'(irq1), 32'h0);
`endif
        run_op("w8 asr7", 32'h0000_0080, 32'h147, 32'h0000_00FF, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/elk_shift_seq.md
# elk_shift_seq

Parametrised, multi-cycle shift/rotate peripheral on the standard slot bus (`cs`/`read`/`write`/`addr`/`wr_data`/`rd_data`). It supports a configurable datapath width and a configurable shift step per cycle, and offers four shift modes. Status is reported through busy/done/overrun flags. It sits on the ALU benchmark bus as the successor to the single-cycle, right/left-only shifter slot.

## Interface
- `WIDTH`, default 32: datapath width, 8..32; operands are zero-extended to 32 bits on read.
- `STEP`, default 4: maximum bits shifted per cycle; must be a power of two, 1..`WIDTH`.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset; all state clears immediately.
- `cs` in 1: slot select.
- `read` in 1: read strobe, qualified by `cs`.
- `write` in 1: write strobe, qualified by `cs`.
- `addr` in 5: register index; decoded by value, `addr[4:2]` must be 0.
- `wr_data` in 32: write data.
- `rd_data` out 32: registered read data.
- `irq` out 1: done interrupt; present only with `ELK_SHIFT_IRQ_EN`.

## Operation
- Let AW = clog2(`WIDTH`).
- Register map:
  - 0 DATA (R/W): `WIDTH`-bit operand.
  - 1 CTRL (W): [AW-1:0] amount, [6:5] mode, [8] start, [9] ie. Mode encoding: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
  - 2 RESULT (R).
  - 3 STATUS (R/W1C): [0] busy, [1] done, [2] ovr.
- Amount bits at or above AW are ignored.
- FSM has two states, IDLE and SHIFT.
  - In IDLE, a CTRL write with start=1 copies DATA into the work register and amount into `remain`, latches mode, clears done, and moves to SHIFT.
  - In SHIFT, each cycle: k = min(`STEP`, `remain`); work shifts or rotates by k; `remain` -= k.
  - When the new `remain` is 0: RESULT ← work, done ← 1, and the FSM returns to IDLE.
  - An amount of 0 still takes one SHIFT cycle (k=0).
- Shift semantics:
  - ASR fills with work[`WIDTH`-1].
  - LSR and LSL fill with 0.
  - ROR is circular within `WIDTH` bits.
- A DATA or CTRL write while busy is ignored and sets ovr. This includes a CTRL write with start=0.
- A CTRL write with start=0 in IDLE updates only the latched ie bit.
- Writing STATUS with bit 2 = 1 clears ovr. Bits 0 and 1 are read-only.
- RESULT holds the previous value until completion. Reads during busy return the old result.
- Write data bits above `WIDTH` are discarded. All reads are zero-extended.
- Unmapped addresses read 0. Writes to them have no effect.

## Timing
- Reset values: `rd_data`=0, DATA=0, RESULT=0, STATUS=0, ie=0, FSM=IDLE, `irq`=0.
- Read latency is 1 cycle. When `cs&&read` is sampled at edge t, `rd_data` holds the addressed value from edge t until the next read.
- Start written at edge t: busy=1 from t through t+N−1, where N = max(1, ceil(amount/`STEP`)).
- At edge t+N: RESULT is valid, done=1, busy=0.
- A new start is accepted at edge t+N or later, giving back-to-back throughput of one operation every N cycles.
- `reset_n` low mid-operation aborts immediately. The aborted result is lost and STATUS reads 0 after release.

## Configuration
- `ELK_SHIFT_IRQ_EN` defined:
  - `irq` port exists, driven as `irq` = done && ie.
  - `irq` is a level signal, cleared by the next accepted start or by reset.
  - CTRL[9] is honoured.
- `ELK_SHIFT_IRQ_EN` undefined:
  - No `irq` port and no ie storage.
  - CTRL[9] is ignored.
  - Polling STATUS.done is the only completion indication.

## Test plan
WIDTH=32, STEP=4 unless noted.

- DATA=0x8000_0001, CTRL amt=4 LSR start → busy for 1 cycle, RESULT=0x0800_0000, STATUS=0x2.
- DATA=0x8000_0000, ASR amt=31 → busy for 8 cycles, RESULT=0xFFFF_FFFF.
- DATA=0x1234_5678, ROR amt=8 → 2 cycles, RESULT=0x7812_3456. DATA=0xA5A5_A5A5, LSL amt=0 → 1 cycle, RESULT=0xA5A5_A5A5.
- CTRL write while busy → ignored, the first result is correct, STATUS=0x6. Then write STATUS=0x4 → STATUS=0x2.
- `reset_n` pulsed low during a 31-bit ASR → `rd_data`=0 and STATUS=0 immediately. A subsequent operation completes normally.
- WIDTH=8, STEP=1: DATA write 0x1FF, LSL amt=3 → DATA reads 0xFF, 3 busy cycles, RESULT=0xF8. With `ELK_SHIFT_IRQ_EN` and ie=1, `irq` rises with done.
